// File: rtl/multicycle_control.sv
// Moore-style control sequencer for the multicycle MIPS datapath.
// Steps each instruction through fetch/decode/execute/memory/writeback, with a timeout on memory waits.
module multicycle_control #(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] OP,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       BranchEQ,
   output logic       BranchNE,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUOp,
   output logic [1:0] PCSource,
   output logic [3:0] State,
   output logic       InstrDone,
   output logic       BusError,
   output logic       IllegalOp
);

   typedef enum logic [3:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      MEM_ADDR  = 4'd2,
      MEM_READ  = 4'd3,
      MEM_WB    = 4'd4,
      MEM_WRITE = 4'd5,
      R_EXEC    = 4'd6,
      R_WB      = 4'd7,
      BRANCH    = 4'd8,
      JUMP      = 4'd9,
      I_EXEC    = 4'd10,
      I_WB      = 4'd11
   } stateT;

   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST =
      TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : {CNT_W{1'b0}};

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   stateT            stateQ, stateD;
   logic [CNT_W-1:0] waitCntQ, waitCntD;
   logic             inWaitState;
   logic             timeoutHit;
   logic             opLegal;

   // Only the three memory-handshake states can stall; a timeout fires on the
   // last permitted wait cycle unless memory answers in that same cycle.
   always_comb begin
      inWaitState = (stateQ == FETCH) || (stateQ == MEM_READ) || (stateQ == MEM_WRITE);
      timeoutHit  = TIMEOUT_EN && inWaitState && !MemReady && (waitCntQ == TIMEOUT_LAST);
      opLegal     = (OP == OP_RTYPE) || (OP == OP_J)    || (OP == OP_JAL) ||
                    (OP == OP_BEQ)   || (OP == OP_BNE)  || (OP == OP_ADDI) ||
                    (OP == OP_ANDI)  || (OP == OP_ORI)  || (OP == OP_LW) ||
                    (OP == OP_SW);
   end

   // The wait counter only climbs while stalled; any state change or a timeout
   // (which may re-enter FETCH) starts the next wait from zero.
   always_comb begin
      waitCntD = '0;
      if (TIMEOUT_EN && inWaitState && !MemReady && !timeoutHit) begin
         waitCntD = waitCntQ + 1'b1;
      end
   end

   // State and wait counter registers; reset drops straight back to FETCH so an
   // interrupted instruction makes no further writes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stateQ   <= FETCH;
         waitCntQ <= '0;
      end else begin
         stateQ   <= stateD;
         waitCntQ <= waitCntD;
      end
   end

   // Next-state logic: the opcode steers DECODE, memory states hold until ready
   // or until the timeout aborts back to FETCH.
   always_comb begin
      stateD = stateQ;
      case (stateQ)
         FETCH: begin
            if (MemReady) begin
               stateD = DECODE;
            end else if (timeoutHit) begin
               stateD = FETCH;
            end
         end
         DECODE: begin
            case (OP)
               OP_RTYPE:               stateD = R_EXEC;
               OP_ADDI, OP_ANDI, OP_ORI: stateD = I_EXEC;
               OP_LW, OP_SW:           stateD = MEM_ADDR;
               OP_BEQ, OP_BNE:         stateD = BRANCH;
               OP_J, OP_JAL:           stateD = JUMP;
               default:                stateD = FETCH;
            endcase
         end
         MEM_ADDR:  stateD = (OP == OP_SW) ? MEM_WRITE : MEM_READ;
         MEM_READ: begin
            if (MemReady) begin
               stateD = MEM_WB;
            end else if (timeoutHit) begin
               stateD = FETCH;
            end
         end
         MEM_WRITE: begin
            if (MemReady || timeoutHit) begin
               stateD = FETCH;
            end
         end
         R_EXEC:    stateD = R_WB;
         I_EXEC:    stateD = I_WB;
         MEM_WB,
         R_WB,
         I_WB,
         BRANCH,
         JUMP:      stateD = FETCH;
         default:   stateD = FETCH;
      endcase
   end

   // Moore outputs per state; FETCH/MEM_WRITE also fold in MemReady so loads and
   // completion land on the cycle memory finishes. Everything is held low in reset.
   always_comb begin
      PCWrite   = 1'b0;
      BranchEQ  = 1'b0;
      BranchNE  = 1'b0;
      IorD      = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      MemtoReg  = 1'b0;
      RegDst    = 1'b0;
      RegWrite  = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      ALUOp     = 3'b000;
      PCSource  = 2'b00;
      InstrDone = 1'b0;
      BusError  = 1'b0;
      IllegalOp = 1'b0;
      if (!reset) begin
         case (stateQ)
            FETCH: begin
               MemRead  = 1'b1;
               ALUSrcB  = 2'b01;
               ALUOp    = 3'b100;
               IRWrite  = MemReady;
               PCWrite  = MemReady;
               BusError = timeoutHit;
            end
            DECODE: begin
               ALUSrcB   = 2'b11;
               ALUOp     = 3'b100;
               IllegalOp = !opLegal;
            end
            MEM_ADDR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
               ALUOp   = (OP == OP_SW) ? 3'b011 : 3'b010;
            end
            MEM_READ: begin
               IorD     = 1'b1;
               MemRead  = 1'b1;
               BusError = timeoutHit;
            end
            MEM_WB: begin
               MemtoReg  = 1'b1;
               RegWrite  = 1'b1;
               InstrDone = 1'b1;
            end
            MEM_WRITE: begin
               IorD      = 1'b1;
               MemWrite  = 1'b1;
               InstrDone = MemReady;
               BusError  = timeoutHit;
            end
            R_EXEC: begin
               ALUSrcA = 1'b1;
               ALUOp   = 3'b111;
            end
            R_WB: begin
               RegDst    = 1'b1;
               RegWrite  = 1'b1;
               InstrDone = 1'b1;
            end
            BRANCH: begin
               ALUSrcA   = 1'b1;
               ALUOp     = 3'b001;
               PCSource  = 2'b01;
               BranchEQ  = (OP == OP_BEQ);
               BranchNE  = (OP == OP_BNE);
               InstrDone = 1'b1;
            end
            JUMP: begin
               PCSource  = 2'b10;
               PCWrite   = 1'b1;
               InstrDone = 1'b1;
            end
            I_EXEC: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
               case (OP)
                  OP_ANDI: ALUOp = 3'b110;
                  OP_ORI:  ALUOp = 3'b101;
                  default: ALUOp = 3'b100;
               endcase
            end
            I_WB: begin
               RegWrite  = 1'b1;
               InstrDone = 1'b1;
            end
            default: begin
               PCWrite = 1'b0;
            end
         endcase
      end
   end

   // The debug state port mirrors the register directly.
   assign State = stateQ;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: a phase-level model predicts every
// cycle's state and control word, plus literal state traces and pulse counts.
module tb_multicycle_control;

   localparam int TO = 15;

   localparam int P_RESET     = -1;
   localparam int P_FETCH     = 0;
   localparam int P_DECODE    = 1;
   localparam int P_MEM_ADDR  = 2;
   localparam int P_MEM_READ  = 3;
   localparam int P_MEM_WB    = 4;
   localparam int P_MEM_WRITE = 5;
   localparam int P_R_EXEC    = 6;
   localparam int P_R_WB      = 7;
   localparam int P_BRANCH    = 8;
   localparam int P_JUMP      = 9;
   localparam int P_I_EXEC    = 10;
   localparam int P_I_WB      = 11;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] OP = 6'h00;
   logic       MemReady = 1'b0;
   logic       PCWrite, BranchEQ, BranchNE, IorD, MemRead, MemWrite, IRWrite;
   logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
   logic [1:0] ALUSrcB, PCSource;
   logic [2:0] ALUOp;
   logic [3:0] State;
   logic       InstrDone, BusError, IllegalOp;

   typedef struct packed {
      logic       pcWrite;
      logic       branchEq;
      logic       branchNe;
      logic       iorD;
      logic       memRead;
      logic       memWrite;
      logic       irWrite;
      logic       memtoReg;
      logic       regDst;
      logic       regWrite;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [2:0] aluOp;
      logic [1:0] pcSource;
      logic       instrDone;
      logic       busError;
      logic       illegalOp;
   } ctrlT;

   typedef struct packed {
      logic [3:0] state;
      ctrlT       ctrl;
   } expT;

   ctrlT dutCtrl;
   expT  expQ[$];
   int   stateLog[$];
   int   checks = 0;
   int   passes = 0;
   int   waitRun = 0;
   int   cycleNo = 0;
   int   busErrorCount = 0;
   int   instrDoneCount = 0;
   int   trace[$];

   multicycle_control #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .OP(OP), .MemReady(MemReady),
      .PCWrite(PCWrite), .BranchEQ(BranchEQ), .BranchNE(BranchNE), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
      .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUOp(ALUOp), .PCSource(PCSource), .State(State), .InstrDone(InstrDone),
      .BusError(BusError), .IllegalOp(IllegalOp)
   );

   always #5 clk = ~clk;

   assign dutCtrl = {PCWrite, BranchEQ, BranchNE, IorD, MemRead, MemWrite, IRWrite,
                     MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
                     InstrDone, BusError, IllegalOp};

   // Shared comparison point: every check goes through here so the pass count
   // in the summary is the one all comparisons update.
   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual == expected) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   function automatic logic opIsLegal(input logic [5:0] op);
      return op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B};
   endfunction

   // Control word the datapath needs in each phase of an instruction.
   function automatic ctrlT ctrlFor(input int phase, input logic [5:0] op,
                                    input logic ready, input logic tmo);
      ctrlT c;
      c = '0;
      case (phase)
         P_FETCH: begin
            c.memRead = 1'b1; c.aluSrcB = 2'b01; c.aluOp = 3'b100;
            c.irWrite = ready; c.pcWrite = ready; c.busError = tmo;
         end
         P_DECODE: begin
            c.aluSrcB = 2'b11; c.aluOp = 3'b100; c.illegalOp = !opIsLegal(op);
         end
         P_MEM_ADDR: begin
            c.aluSrcA = 1'b1; c.aluSrcB = 2'b10;
            c.aluOp = (op == 6'h2B) ? 3'b011 : 3'b010;
         end
         P_MEM_READ: begin
            c.iorD = 1'b1; c.memRead = 1'b1; c.busError = tmo;
         end
         P_MEM_WB: begin
            c.memtoReg = 1'b1; c.regWrite = 1'b1; c.instrDone = 1'b1;
         end
         P_MEM_WRITE: begin
            c.iorD = 1'b1; c.memWrite = 1'b1; c.instrDone = ready; c.busError = tmo;
         end
         P_R_EXEC: begin
            c.aluSrcA = 1'b1; c.aluOp = 3'b111;
         end
         P_R_WB: begin
            c.regDst = 1'b1; c.regWrite = 1'b1; c.instrDone = 1'b1;
         end
         P_BRANCH: begin
            c.aluSrcA = 1'b1; c.aluOp = 3'b001; c.pcSource = 2'b01; c.instrDone = 1'b1;
            c.branchEq = (op == 6'h04); c.branchNe = (op == 6'h05);
         end
         P_JUMP: begin
            c.pcSource = 2'b10; c.pcWrite = 1'b1; c.instrDone = 1'b1;
         end
         P_I_EXEC: begin
            c.aluSrcA = 1'b1; c.aluSrcB = 2'b10;
            c.aluOp = (op == 6'h0C) ? 3'b110 : (op == 6'h0D) ? 3'b101 : 3'b100;
         end
         P_I_WB: begin
            c.regWrite = 1'b1; c.instrDone = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   // One clock of stimulus: drive inputs just after the edge and queue what the
   // outputs must be for the rest of that cycle. Tracks stall length for timeouts.
   task automatic step(input int phase, input logic ready, input logic [5:0] op,
                       input logic rst, output logic tmo);
      expT e;
      @(posedge clk);
      #1;
      reset    = rst;
      MemReady = ready;
      OP       = op;
      cycleNo++;
      tmo = 1'b0;
      if ((phase == P_FETCH || phase == P_MEM_READ || phase == P_MEM_WRITE) && !ready) begin
         waitRun++;
         if (waitRun == TO) begin
            tmo = 1'b1;
            waitRun = 0;
         end
      end else begin
         waitRun = 0;
      end
      e.state = (phase < 0) ? 4'd0 : 4'(phase);
      e.ctrl  = (phase < 0) ? '0 : ctrlFor(phase, op, ready, tmo);
      expQ.push_back(e);
   endtask

   // Walk one whole instruction through its phases with the given memory stalls.
   task automatic applyStimulus(input logic [5:0] op, input int fetchWaits, input int memWaits);
      logic tmo;
      for (int i = 0; i <= fetchWaits; i++) step(P_FETCH, (i == fetchWaits), op, 1'b0, tmo);
      step(P_DECODE, 1'b1, op, 1'b0, tmo);
      case (op)
         6'h00: begin
            step(P_R_EXEC, 1'b1, op, 1'b0, tmo);
            step(P_R_WB, 1'b0, op, 1'b0, tmo);
         end
         6'h08, 6'h0C, 6'h0D: begin
            step(P_I_EXEC, 1'b1, op, 1'b0, tmo);
            step(P_I_WB, 1'b0, op, 1'b0, tmo);
         end
         6'h23: begin
            step(P_MEM_ADDR, 1'b1, op, 1'b0, tmo);
            for (int i = 0; i <= memWaits; i++) begin
               step(P_MEM_READ, (i == memWaits), op, 1'b0, tmo);
               if (tmo) return;
            end
            step(P_MEM_WB, 1'b1, op, 1'b0, tmo);
         end
         6'h2B: begin
            step(P_MEM_ADDR, 1'b1, op, 1'b0, tmo);
            for (int i = 0; i <= memWaits; i++) begin
               step(P_MEM_WRITE, (i == memWaits), op, 1'b0, tmo);
               if (tmo) return;
            end
         end
         6'h04, 6'h05: step(P_BRANCH, 1'b1, op, 1'b0, tmo);
         6'h02, 6'h03: step(P_JUMP, 1'b1, op, 1'b0, tmo);
         default: ;
      endcase
   endtask

   task automatic resetDut(input int cycles);
      logic tmo;
      for (int i = 0; i < cycles; i++) step(P_RESET, 1'b0, 6'h00, 1'b1, tmo);
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic checkTrace(input string name, input int expTrace[$]);
      checkOutput({name, " length"}, stateLog.size(), expTrace.size());
      for (int i = 0; i < expTrace.size() && i < stateLog.size(); i++) begin
         checkOutput($sformatf("%s[%0d]", name, i), stateLog[i], expTrace[i]);
      end
      stateLog.delete();
   endtask

   // Per-cycle compare against the model, mid-cycle where inputs are settled.
   always @(negedge clk) begin
      expT e;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         checkOutput($sformatf("cycle%0d state+ctrl", cycleNo), int'({State, dutCtrl}), int'(e));
         stateLog.push_back(int'(State));
         if (BusError) busErrorCount++;
         if (InstrDone) instrDoneCount++;
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic tmo;
      $display("[TB] multicycle_control bench starting");
      resetDut(3);
      settle();
      stateLog.delete();

      applyStimulus(6'h00, 0, 0);
      settle();
      trace = '{0, 1, 6, 7};
      checkTrace("rTypeTrace", trace);

      applyStimulus(6'h23, 0, 3);
      settle();
      trace = '{0, 1, 2, 3, 3, 3, 3, 4};
      checkTrace("lwTrace", trace);

      applyStimulus(6'h2B, 0, 2);
      settle();
      trace = '{0, 1, 2, 5, 5, 5};
      checkTrace("swTrace", trace);

      applyStimulus(6'h04, 0, 0);
      settle();
      trace = '{0, 1, 8};
      checkTrace("beqTrace", trace);

      applyStimulus(6'h05, 1, 0);
      settle();
      trace = '{0, 0, 1, 8};
      checkTrace("bneTrace", trace);

      applyStimulus(6'h08, 0, 0);
      applyStimulus(6'h0C, 0, 0);
      applyStimulus(6'h0D, 0, 0);
      settle();
      stateLog.delete();
      checkOutput("instrDoneCount", instrDoneCount, 8);

      applyStimulus(6'h00, 15, 0);
      settle();
      checkOutput("fetchTimeoutBusErrors", busErrorCount, 1);

      applyStimulus(6'h00, 14, 0);
      settle();
      checkOutput("readyWinsBusErrors", busErrorCount, 1);

      applyStimulus(6'h2B, 0, 20);
      settle();
      checkOutput("writeTimeoutBusErrors", busErrorCount, 2);
      checkOutput("instrDoneAfterAbort", instrDoneCount, 10);
      stateLog.delete();

      applyStimulus(6'h3F, 0, 0);
      settle();
      trace = '{0, 1};
      checkTrace("illegalTrace", trace);

      applyStimulus(6'h02, 0, 0);
      settle();
      trace = '{0, 1, 9};
      checkTrace("jumpTrace", trace);
      applyStimulus(6'h03, 0, 0);

      step(P_FETCH, 1'b1, 6'h2B, 1'b0, tmo);
      step(P_DECODE, 1'b1, 6'h2B, 1'b0, tmo);
      step(P_MEM_ADDR, 1'b1, 6'h2B, 1'b0, tmo);
      step(P_MEM_WRITE, 1'b0, 6'h2B, 1'b0, tmo);
      @(negedge clk);
      #1;
      checkOutput("memWriteBeforeReset", int'(MemWrite), 1);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("memWriteInReset", int'(MemWrite), 0);
      checkOutput("stateInReset", int'(State), 0);
      checkOutput("ctrlInReset", int'(dutCtrl), 0);
      resetDut(2);
      settle();
      stateLog.delete();

      applyStimulus(6'h00, 0, 0);
      settle();
      trace = '{0, 1, 6, 7};
      checkTrace("recoveryTrace", trace);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
